cpu_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle core. It owns the instruction-memory write port during program load and gates the core's PC/register/memory update enable. It handles halt/resume/single-step from the simulator or debug side, and halts on EBREAK or watchdog expiry. It sits beside cpu_top: it drives the core enable and core reset, and observes the fetched instruction and current PC.

---
 rtl/cpu_run_ctrl_pkg.sv | 19 +
 rtl/cpu_run_ctrl_wdog.sv | 39 +++
 rtl/cpu_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding,
// halt-cause codes and the default EBREAK encoding.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_DBG    = 2'd1;
  localparam logic [1:0] CAUSE_EBREAK = 2'd2;
  localparam logic [1:0] CAUSE_WDOG   = 2'd3;

  localparam logic [31:0] EBREAK_INST_DEFAULT = 32'h0010_0073;

endpackage

// File: rtl/cpu_run_ctrl_wdog.sv
// Watchdog for the run controller: a clearable counter of retired RUN
// instructions that flags expiry once LIMIT of them have retired.
// LIMIT == 0 disables expiry entirely.
module run_wdog #(
  parameter int unsigned LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [31:0] count_q, count_d;

  // Next count: clear wins over increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle core: owns the
// instruction-memory write port during load, gates core commit, and
// handles halt/resume/step plus EBREAK and watchdog self-halts.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_AW     = 12,
  parameter logic [31:0] EBREAK_INST = EBREAK_INST_DEFAULT,
  parameter int unsigned WDOG_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [IMEM_AW-1:0] load_addr_i,
  input  logic [31:0]        load_data_i,
  input  logic               load_last_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  input  logic               dbg_halt_i,
  input  logic               dbg_resume_i,
  input  logic               dbg_step_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        pc_i,
  output logic               core_rst_o,
  output logic               core_en_o,
  output logic               halted_o,
  output logic [1:0]         halt_cause_o,
  output logic [31:0]        halt_pc_o,
  output logic [31:0]        retired_o
);

  run_state_e         state_q, state_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        halt_pc_q, halt_pc_d;
  logic [31:0]        retired_q, retired_d;
  logic               skip_ebreak_q, skip_ebreak_d;  // first RUN cycle after resume retires an EBREAK
  logic               core_en;
  logic [1:0]         hit_cause;
  logic               resume;
  logic               wdog_expired;

  assign resume = (state_q == ST_HALT) && dbg_resume_i && !dbg_step_i;

  run_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (resume),
    .inc_i     ((state_q == ST_RUN) && core_en),
    .expired_o (wdog_expired)
  );

  // Next state, commit enable and halt detection.
  always_comb begin
    state_d   = state_q;
    core_en   = 1'b0;
    hit_cause = CAUSE_NONE;
    case (state_q)
      ST_LOAD: begin
        if (load_valid_i && load_last_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dbg_halt_i)                                  hit_cause = CAUSE_DBG;
        else if (inst_i == EBREAK_INST && !skip_ebreak_q) hit_cause = CAUSE_EBREAK;
        else if (wdog_expired)                           hit_cause = CAUSE_WDOG;
        if (hit_cause != CAUSE_NONE) state_d = ST_HALT;
        else                         core_en = 1'b1;
      end
      ST_HALT: begin
        if (dbg_step_i)        state_d = ST_STEP;
        else if (dbg_resume_i) state_d = ST_RUN;
      end
      ST_STEP: begin
        core_en = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Next values for the load write port and the halt/retire bookkeeping.
  always_comb begin
    imem_we_d     = (state_q == ST_LOAD) && load_valid_i;
    imem_addr_d   = imem_we_d ? load_addr_i : imem_addr_q;
    imem_wdata_d  = imem_we_d ? load_data_i : imem_wdata_q;
    retired_d     = core_en ? retired_q + 32'd1 : retired_q;
    halt_pc_d     = halt_pc_q;
    cause_d       = cause_q;
    skip_ebreak_d = skip_ebreak_q;
    // While halted the core is frozen, so tracking pc_i also picks up the post-step PC.
    if (state_q == ST_HALT || (state_q == ST_RUN && hit_cause != CAUSE_NONE)) halt_pc_d = pc_i;
    if (state_q == ST_RUN) begin
      skip_ebreak_d = 1'b0;
      if (hit_cause != CAUSE_NONE) cause_d = hit_cause;
    end
    if (resume) begin
      cause_d       = CAUSE_NONE;
      skip_ebreak_d = 1'b1;
    end
    if (state_q == ST_STEP) cause_d = CAUSE_DBG;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      cause_q       <= CAUSE_NONE;
      halt_pc_q     <= '0;
      retired_q     <= '0;
      skip_ebreak_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      cause_q       <= cause_d;
      halt_pc_q     <= halt_pc_d;
      retired_q     <= retired_d;
      skip_ebreak_q <= skip_ebreak_d;
    end
  end

  assign load_ready_o = (state_q == ST_LOAD);
  assign core_rst_o   = (state_q == ST_LOAD);
  assign halted_o     = (state_q == ST_HALT);
  assign core_en_o    = core_en;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign halt_cause_o = cause_q;
  assign halt_pc_o    = halt_pc_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy core (PC + instruction memory fed by the
// controller's write port) surrounds the DUT; a behavioural model checks
// every output on every cycle, and directed sequences pin the model.
module tb_cpu_run_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned WD = 5;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] JSELF = 32'h0000_006f;  // jal x0,0: spins on itself

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_last;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          dbg_halt, dbg_resume, dbg_step;
  logic          load_ready_o, imem_we_o, core_rst_o, core_en_o, halted_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o, halt_pc_o, retired_o, inst_i, pc_i;
  logic [1:0]    halt_cause_o;

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int we_count = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.IMEM_AW(AW), .EBREAK_INST(EBRK), .WDOG_CYCLES(WD)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready_o),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .dbg_halt_i   (dbg_halt),
    .dbg_resume_i (dbg_resume),
    .dbg_step_i   (dbg_step),
    .inst_i       (inst_i),
    .pc_i         (pc_i),
    .core_rst_o   (core_rst_o),
    .core_en_o    (core_en_o),
    .halted_o     (halted_o),
    .halt_cause_o (halt_cause_o),
    .halt_pc_o    (halt_pc_o),
    .retired_o    (retired_o)
  );

  // Toy core: memory written by the controller, PC advances on commit.
  bit [31:0] mem [0:(1<<AW)-1];
  bit [31:0] pc_q;
  assign pc_i   = pc_q;
  assign inst_i = mem[pc_q[AW+1:2]];

  always @(posedge clk) begin
    if (imem_we_o) mem[imem_addr_o] <= imem_wdata_o;
    if (core_rst_o)     pc_q <= 32'd0;
    else if (core_en_o) pc_q <= (inst_i == JSELF) ? pc_q : pc_q + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: phase, pending-write queue, retired budget per RUN.
  typedef enum int {PH_LOAD, PH_RUN, PH_HALT, PH_STEP} phase_e;
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } beat_t;

  phase_e        m_phase = PH_LOAD;
  beat_t         m_wq[$];
  logic [AW-1:0] m_waddr = '0;
  logic [31:0]   m_wdata = '0;
  logic [31:0]   m_retired = '0, m_halt_pc = '0;
  int            m_cause = 0;
  int            m_budget = WD;   // instructions still allowed before watchdog halt
  bit            m_fresh = 1'b0;  // just resumed: an EBREAK here retires

  always @(negedge clk) begin : scoreboard
    bit exp_we, exp_en;
    int stop;
    if (rst) begin
      m_phase = PH_LOAD; m_wq.delete(); m_waddr = '0; m_wdata = '0;
      m_retired = '0; m_halt_pc = '0; m_cause = 0; m_budget = WD; m_fresh = 1'b0;
    end
    exp_we = 1'b0;
    if (m_wq.size() != 0) begin
      exp_we = 1'b1;
      m_waddr = m_wq[0].a;
      m_wdata = m_wq[0].d;
      void'(m_wq.pop_front());
    end
    stop = 0;
    if (m_phase == PH_RUN) begin
      if (dbg_halt)                    stop = 1;
      else if (inst_i == EBRK && !m_fresh) stop = 2;
      else if (m_budget == 0)          stop = 3;
    end
    exp_en = (m_phase == PH_STEP) || (m_phase == PH_RUN && stop == 0);

    check("load_ready", load_ready_o, m_phase == PH_LOAD);
    check("core_rst",   core_rst_o,   m_phase == PH_LOAD);
    check("halted",     halted_o,     m_phase == PH_HALT);
    check("core_en",    core_en_o,    exp_en);
    check("imem_we",    imem_we_o,    exp_we);
    check("imem_addr",  imem_addr_o,  m_waddr);
    check("imem_wdata", imem_wdata_o, m_wdata);
    check("halt_cause", halt_cause_o, m_cause);
    check("halt_pc",    halt_pc_o,    m_halt_pc);
    check("retired",    retired_o,    m_retired);
    if (core_en_o) en_count++;
    if (imem_we_o) we_count++;

    if (!rst) begin
      case (m_phase)
        PH_LOAD: begin
          if (load_valid) begin
            m_wq.push_back('{a: load_addr, d: load_data});
            if (load_last) m_phase = PH_RUN;
          end
        end
        PH_RUN: begin
          m_fresh = 1'b0;
          if (stop != 0) begin
            m_phase = PH_HALT; m_cause = stop; m_halt_pc = pc_i;
          end else begin
            m_retired++; m_budget--;
          end
        end
        PH_HALT: begin
          m_halt_pc = pc_i;
          if (dbg_step) m_phase = PH_STEP;
          else if (dbg_resume) begin
            m_phase = PH_RUN; m_cause = 0; m_budget = WD; m_fresh = 1'b1;
          end
        end
        PH_STEP: begin
          m_retired++; m_cause = 1; m_phase = PH_HALT;
        end
        default: m_phase = PH_LOAD;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input int a, input logic [31:0] d, input bit last);
    load_valid = 1'b1; load_addr = AW'(a); load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic wait_halted(input int max, input string name);
    int n = 0;
    while (!halted_o && n < max) begin
      tick();
      n++;
    end
    check(name, halted_o, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_inst();
    case ($urandom_range(0, 3))
      0:       return NOP;
      1:       return EBRK;
      2:       return JSELF;
      default: return ADDI;
    endcase
  endfunction

  initial begin : stimulus
    int e0, w0, n;
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_addr = '0; load_data = '0;
    dbg_halt = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
    tick(); tick();
    check("rst_ready",   load_ready_o, 1'b1);
    check("rst_core_rst", core_rst_o,  1'b1);
    check("rst_core_en", core_en_o,    1'b0);
    check("rst_retired", retired_o,    32'd0);
    rst = 1'b0;

    // Load and run a three-word image ending in EBREAK.
    w0 = we_count; e0 = en_count;
    load_beat(0, NOP, 1'b0);
    load_beat(1, ADDI, 1'b0);
    load_beat(2, EBRK, 1'b1);
    check("t1_last_we",      imem_we_o,   1'b1);
    check("t1_last_addr",    imem_addr_o, 32'd2);
    check("t1_core_rst_low", core_rst_o,  1'b0);
    wait_halted(20, "t2_halt_reached");
    check("t1_we_pulses",  we_count - w0,  32'd3);
    check("t2_en_cycles",  en_count - e0,  32'd2);
    check("t2_retired",    retired_o,      32'd2);
    check("t2_cause",      halt_cause_o,   32'd2);
    check("t2_halt_pc",    halt_pc_o,      32'h8);

    // Single step over the EBREAK.
    e0 = en_count;
    dbg_step = 1'b1; tick(); dbg_step = 1'b0;
    check("t3_in_step", halted_o, 1'b0);
    tick(); tick();
    check("t3_en_cycles", en_count - e0, 32'd1);
    check("t3_retired",   retired_o,     32'd3);
    check("t3_cause",     halt_cause_o,  32'd1);
    check("t3_halted",    halted_o,      1'b1);
    check("t3_halt_pc",   halt_pc_o,     32'hc);

    // Debug halt coinciding with an EBREAK fetch.
    do_reset();
    load_beat(0, NOP, 1'b0);
    load_beat(1, EBRK, 1'b1);
    n = 0;
    while (!(inst_i == EBRK && !core_rst_o && !halted_o) && n < 20) begin
      tick();
      n++;
    end
    check("t4_ebreak_fetched", inst_i, EBRK);
    dbg_halt = 1'b1; tick(); dbg_halt = 1'b0;
    check("t4_cause_dbg", halt_cause_o, 32'd1);
    check("t4_halt_pc",   halt_pc_o,    32'h4);
    e0 = en_count;
    dbg_resume = 1'b1; dbg_step = 1'b1; tick(); dbg_resume = 1'b0; dbg_step = 1'b0;
    check("t4_step_wins", halted_o, 1'b0);
    tick(); tick();
    check("t4_en_cycles", en_count - e0, 32'd1);
    check("t4_retired",   retired_o,     32'd2);
    // Resume onto the EBREAK left at word 2 by the first image.
    dbg_resume = 1'b1; tick(); dbg_resume = 1'b0;
    check("t4_resume_fetch", inst_i,    EBRK);
    check("t4_ebreak_noop",  core_en_o, 1'b1);
    wait_halted(20, "t4_wdog_halt");
    check("t4_wdog_cause",   halt_cause_o, 32'd3);
    check("t4_wdog_retired", retired_o,    32'd7);

    // Watchdog on a spin loop.
    do_reset();
    load_beat(0, JSELF, 1'b0);
    load_beat(1, JSELF, 1'b1);
    wait_halted(20, "t5_first_halt");
    check("t5_retired_5", retired_o,    32'd5);
    check("t5_cause",     halt_cause_o, 32'd3);
    check("t5_halt_pc",   halt_pc_o,    32'h0);
    dbg_resume = 1'b1; tick(); dbg_resume = 1'b0;
    wait_halted(20, "t5_second_halt");
    check("t5_retired_10", retired_o,    32'd10);
    check("t5_cause2",     halt_cause_o, 32'd3);

    // Asynchronous reset mid-load and mid-run.
    do_reset();
    load_beat(0, NOP, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_load_we",    imem_we_o,    1'b0);
    check("t6_load_addr",  imem_addr_o,  32'd0);
    check("t6_load_ready", load_ready_o, 1'b1);
    tick(); rst = 1'b0;
    load_beat(0, JSELF, 1'b0);
    load_beat(1, JSELF, 1'b1);
    tick(); tick();
    check("t6_running", core_en_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_run_en",      core_en_o,    1'b0);
    check("t6_run_corerst", core_rst_o,   1'b1);
    check("t6_run_retired", retired_o,    32'd0);
    check("t6_run_ready",   load_ready_o, 1'b1);
    check("t6_run_halted",  halted_o,     1'b0);
    tick(); rst = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      load_addr  = AW'($urandom_range(0, 7));
      load_data  = pick_inst();
      load_last  = ($urandom_range(0, 5) == 0);
      dbg_halt   = ($urandom_range(0, 15) == 0);
      dbg_resume = ($urandom_range(0, 5) == 0);
      dbg_step   = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0; dbg_halt = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
